// File: rtl/cnt_obi_arb.sv
// Round-robin OBI arbiter: NUM_REQ requesters share one counter OBI port.
// Responses are steered back through a small FIFO of granted requester indices.

package cnt_obi_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    sbr_obi_a_chan_t a;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    sbr_obi_r_chan_t r;
  } sbr_obi_rsp_t;

endpackage

module cnt_obi_arb
  import cnt_obi_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  sbr_obi_req_t [NUM_REQ-1:0] req_i,
  output sbr_obi_rsp_t [NUM_REQ-1:0] rsp_o,
  output sbr_obi_req_t               mgr_req_o,
  input  sbr_obi_rsp_t               mgr_rsp_i,
  output logic                       err_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned PtrW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTST + 1);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  idx_t rr_ptr_q, rr_ptr_d;
  idx_t lock_idx_q, lock_idx_d;
  logic lock_q, lock_d;
  idx_t fifo_q [MAX_OUTST];
  ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t cnt_q, cnt_d;
  logic err_q, err_d;

  idx_t winner, head;
  logic any_req, full, empty, hs, pop;

  assign full  = (cnt_q == cnt_t'(MAX_OUTST));
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rd_ptr_q];

  // A pending (locked) address phase must stay stable, so the search is bypassed.
  always_comb begin
    int unsigned sum;
    idx_t        cand;
    winner  = rr_ptr_q;
    any_req = 1'b0;
    sum     = 0;
    cand    = '0;
    if (lock_q) begin
      winner  = lock_idx_q;
      any_req = req_i[lock_idx_q].req;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        sum  = 32'(rr_ptr_q) + k;
        cand = idx_t'(sum % NUM_REQ);
        if (!any_req && req_i[cand].req) begin
          winner  = cand;
          any_req = 1'b1;
        end
      end
    end
  end

  always_comb begin
    mgr_req_o     = req_i[winner];
    mgr_req_o.req = any_req & ~full;
  end

  assign hs  = mgr_req_o.req & mgr_rsp_i.gnt;
  assign pop = mgr_rsp_i.rvalid & ~empty;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_o[i] = '0;
      if (idx_t'(i) == winner) begin
        rsp_o[i].gnt = hs;
      end
      if (pop && (head == idx_t'(i))) begin
        rsp_o[i].rvalid = 1'b1;
        rsp_o[i].r      = mgr_rsp_i.r;
      end
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    err_d      = err_q | (mgr_rsp_i.rvalid & empty);

    if (hs) begin
      rr_ptr_d = (winner == idx_t'(NUM_REQ - 1)) ? '0 : winner + idx_t'(1);
      lock_d   = 1'b0;
      wr_ptr_d = (wr_ptr_q == ptr_t'(MAX_OUTST - 1)) ? '0 : wr_ptr_q + ptr_t'(1);
    end else if (mgr_req_o.req && !lock_q) begin
      lock_d     = 1'b1;
      lock_idx_d = winner;
    end

    if (pop) begin
      rd_ptr_d = (rd_ptr_q == ptr_t'(MAX_OUTST - 1)) ? '0 : rd_ptr_q + ptr_t'(1);
    end

    unique case ({hs, pop})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Routing storage needs no reset: entries are only read when cnt_q says valid.
  always_ff @(posedge clk_i) begin
    if (hs) begin
      fifo_q[wr_ptr_q] <= winner;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_cnt_obi_arb.sv
// Directed bench for cnt_obi_arb (NUM_REQ=2, MAX_OUTST=2); the bench plays the counter side.
module tb_cnt_obi_arb;
  import cnt_obi_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  sbr_obi_req_t [1:0] req;
  sbr_obi_rsp_t [1:0] rsp;
  sbr_obi_req_t       mreq;
  sbr_obi_rsp_t       mrsp;
  logic               err;

  int n_cmp  = 0;
  int n_fail = 0;
  int sb_q[$];

  cnt_obi_arb #(
    .NUM_REQ  (2),
    .MAX_OUTST(2)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req),
    .rsp_o    (rsp),
    .mgr_req_o(mreq),
    .mgr_rsp_i(mrsp),
    .err_o    (err)
  );

  task automatic idle();
    req  = '0;
    mrsp = '0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_ni = 1'b0;
    tick();
    @(negedge clk_i);
    n_cmp++;
    if ({err, rsp[1].rvalid, rsp[0].rvalid, mreq.req} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=0000", {err, rsp[1].rvalid, rsp[0].rvalid, mreq.req});
    end
    n_cmp++;
    if ({dut.lock_q, dut.cnt_q, dut.rr_ptr_q} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got=%b exp=0", {dut.lock_q, dut.cnt_q, dut.rr_ptr_q});
    end
    tick();
    rst_ni = 1'b1;
    req[0].req    = 1'b1;
    req[0].a.addr = 32'h40;
    @(negedge clk_i);
    n_cmp++;
    if ({mreq.req, mreq.a.addr, rsp[1].gnt, rsp[0].gnt} !== {1'b1, 32'h40, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_comb_pass got=%b/%h/%b%b exp=1/00000040/00",
               mreq.req, mreq.a.addr, rsp[1].gnt, rsp[0].gnt);
    end
    do_reset();
  endtask

  task automatic test_round_robin();
    int h;
    do_reset();
    sb_q.delete();
    req[0].req = 1'b1; req[0].a.addr = 32'h10;
    req[1].req = 1'b1; req[1].a.addr = 32'h14;
    mrsp.gnt   = 1'b1;
    for (int k = 0; k < 7; k++) begin
      mrsp.rvalid  = (k > 0);
      mrsp.r.rdata = 32'h100 + k - 1;
      if (k == 6) begin
        req[0].req = 1'b0;
        req[1].req = 1'b0;
      end
      @(negedge clk_i);
      if (k < 6) begin
        n_cmp++;
        if ({rsp[1].gnt, rsp[0].gnt} !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL rr_gnt k=%0d got=%b%b exp_winner=%0d", k, rsp[1].gnt, rsp[0].gnt, k % 2);
        end
        n_cmp++;
        if (mreq.a.addr !== ((k % 2 == 1) ? 32'h14 : 32'h10)) begin
          n_fail++;
          $display("FAIL rr_addr k=%0d got=%h exp_winner=%0d", k, mreq.a.addr, k % 2);
        end
        sb_q.push_back(k % 2);
      end
      if (k > 0) begin
        h = sb_q.pop_front();
        n_cmp++;
        if ({rsp[1].rvalid, rsp[0].rvalid} !== ((h == 1) ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL rr_route k=%0d got=%b%b exp_dest=%0d", k, rsp[1].rvalid, rsp[0].rvalid, h);
        end
        n_cmp++;
        if (rsp[h].r.rdata !== 32'h100 + k - 1 || rsp[1-h].r !== '0) begin
          n_fail++;
          $display("FAIL rr_rdata k=%0d got=%h other=%h exp=%h other=0",
                   k, rsp[h].r.rdata, rsp[1-h].r, 32'h100 + k - 1);
        end
      end
      tick();
    end
    idle();
    @(negedge clk_i);
    n_cmp++;
    if (err !== 1'b0 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL rr_end got err=%b left=%0d exp err=0 left=0", err, sb_q.size());
    end
  endtask

  task automatic test_lock();
    do_reset();
    req[0] = '{req: 1'b1, a: '{addr: 32'h20, we: 1'b1, be: 4'hf, wdata: 32'h5}};
    req[1].req = 1'b1; req[1].a.addr = 32'h24;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      n_cmp++;
      if ({mreq.req, mreq.a.addr, mreq.a.we, mreq.a.wdata, rsp[1].gnt, rsp[0].gnt}
          !== {1'b1, 32'h20, 1'b1, 32'h5, 2'b00}) begin
        n_fail++;
        $display("FAIL lock_hold k=%0d got req=%b addr=%h wdata=%h gnt=%b%b exp 1/20/5/00",
                 k, mreq.req, mreq.a.addr, mreq.a.wdata, rsp[1].gnt, rsp[0].gnt);
      end
      tick();
    end
    mrsp.gnt = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if ({rsp[1].gnt, rsp[0].gnt} !== 2'b01) begin
      n_fail++;
      $display("FAIL lock_release got=%b%b exp=01", rsp[1].gnt, rsp[0].gnt);
    end
    tick();
    req[0] = '0;
    mrsp.rvalid = 1'b1; mrsp.r.rdata = 32'h55;
    @(negedge clk_i);
    n_cmp++;
    if ({rsp[1].gnt, rsp[0].gnt, rsp[1].rvalid, rsp[0].rvalid, rsp[0].r.rdata, mreq.a.addr}
        !== {4'b1001, 32'h55, 32'h24}) begin
      n_fail++;
      $display("FAIL lock_next got gnt=%b%b rv=%b%b rdata=%h addr=%h exp 10/01/55/24",
               rsp[1].gnt, rsp[0].gnt, rsp[1].rvalid, rsp[0].rvalid, rsp[0].r.rdata, mreq.a.addr);
    end
    tick();
    req[1].req = 1'b0;
    mrsp.r.rdata = 32'h66;
    @(negedge clk_i);
    n_cmp++;
    if ({rsp[1].gnt, rsp[0].gnt, rsp[1].rvalid, rsp[0].rvalid, rsp[1].r.rdata}
        !== {4'b0010, 32'h66}) begin
      n_fail++;
      $display("FAIL lock_rsp1 got gnt=%b%b rv=%b%b rdata=%h exp 00/10/66",
               rsp[1].gnt, rsp[0].gnt, rsp[1].rvalid, rsp[0].rvalid, rsp[1].r.rdata);
    end
    tick();
    // Requester 1 locks, then illegally drops req while requester 0 asks.
    mrsp = '0;
    req[1].req = 1'b1; req[1].a.addr = 32'h28;
    @(negedge clk_i);
    n_cmp++;
    if ({mreq.req, mreq.a.addr} !== {1'b1, 32'h28}) begin
      n_fail++;
      $display("FAIL drop_setup got req=%b addr=%h exp 1/28", mreq.req, mreq.a.addr);
    end
    tick();
    req[1].req = 1'b0;
    req[0].req = 1'b1;
    mrsp.gnt   = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if ({mreq.req, rsp[1].gnt, rsp[0].gnt} !== 3'b000) begin
      n_fail++;
      $display("FAIL drop_keep_lock got req=%b gnt=%b%b exp 0/00", mreq.req, rsp[1].gnt, rsp[0].gnt);
    end
    tick();
    req[1].req = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if ({rsp[1].gnt, rsp[0].gnt, mreq.a.addr} !== {2'b10, 32'h28}) begin
      n_fail++;
      $display("FAIL drop_regrant got gnt=%b%b addr=%h exp 10/28", rsp[1].gnt, rsp[0].gnt, mreq.a.addr);
    end
    tick();
    req[1].req = 1'b0;
    mrsp.rvalid = 1'b1; mrsp.r.rdata = 32'h77;
    @(negedge clk_i);
    n_cmp++;
    if ({rsp[1].gnt, rsp[0].gnt, rsp[1].rvalid, rsp[0].rvalid, rsp[1].r.rdata}
        !== {4'b0110, 32'h77}) begin
      n_fail++;
      $display("FAIL drop_after got gnt=%b%b rv=%b%b rdata=%h exp 01/10/77",
               rsp[1].gnt, rsp[0].gnt, rsp[1].rvalid, rsp[0].rvalid, rsp[1].r.rdata);
    end
    tick();
    req = '0;
    mrsp.gnt = 1'b0; mrsp.r.rdata = 32'h88;
    @(negedge clk_i);
    n_cmp++;
    if ({rsp[1].rvalid, rsp[0].rvalid, rsp[0].r.rdata, rsp[1].r} !== {2'b01, 32'h88, 33'h0}) begin
      n_fail++;
      $display("FAIL drop_drain got rv=%b%b rdata=%h exp 01/88", rsp[1].rvalid, rsp[0].rvalid,
               rsp[0].r.rdata);
    end
    tick();
    idle();
  endtask

  task automatic test_full();
    // Per cycle: req0, rvalid, rdata, expected mreq.req, gnt0, rvalid0.
    logic        t_req [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic        t_rv  [10] = '{0, 0, 0, 0, 1, 0, 1, 1, 1, 0};
    logic [31:0] t_rd  [10] = '{0, 0, 0, 0, 32'hA0, 0, 32'hA1, 32'hA2, 32'hA3, 0};
    logic        e_mrq [10] = '{1, 1, 0, 0, 0, 1, 0, 1, 0, 0};
    do_reset();
    req[0].a.addr = 32'h30;
    mrsp.gnt = 1'b1;
    for (int k = 0; k < 10; k++) begin
      req[0].req   = t_req[k];
      mrsp.rvalid  = t_rv[k];
      mrsp.r.rdata = t_rd[k];
      @(negedge clk_i);
      n_cmp++;
      if ({mreq.req, rsp[0].gnt, rsp[1].gnt, rsp[0].rvalid, rsp[1].rvalid, rsp[0].r.rdata}
          !== {e_mrq[k], e_mrq[k], 1'b0, t_rv[k], 1'b0, t_rd[k]}) begin
        n_fail++;
        $display("FAIL full k=%0d got req=%b gnt=%b%b rv=%b%b rdata=%h exp req=%b gnt0=%b rv0=%b rdata=%h",
                 k, mreq.req, rsp[1].gnt, rsp[0].gnt, rsp[1].rvalid, rsp[0].rvalid,
                 rsp[0].r.rdata, e_mrq[k], e_mrq[k], t_rv[k], t_rd[k]);
      end
      tick();
    end
    @(negedge clk_i);
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL full_err got=%b exp=0", err);
    end
    idle();
  endtask

  task automatic test_unsolicited();
    do_reset();
    mrsp.rvalid = 1'b1; mrsp.r.rdata = 32'hDEAD;
    @(negedge clk_i);
    n_cmp++;
    if ({err, rsp[1].rvalid, rsp[0].rvalid, rsp[0].r, rsp[1].r} !== '0) begin
      n_fail++;
      $display("FAIL unsol_same got err=%b rv=%b%b exp 0/00", err, rsp[1].rvalid, rsp[0].rvalid);
    end
    tick();
    mrsp = '0;
    for (int k = 0; k < 3; k++) begin
      req[0].req  = (k == 1);
      mrsp.gnt    = (k == 1);
      mrsp.rvalid = (k == 2);
      mrsp.r.rdata = 32'hB0;
      @(negedge clk_i);
      n_cmp++;
      if ({err, rsp[0].gnt, rsp[0].rvalid} !== {1'b1, k == 1, k == 2}) begin
        n_fail++;
        $display("FAIL unsol_sticky k=%0d got err=%b gnt0=%b rv0=%b exp 1/%0b/%0b",
                 k, err, rsp[0].gnt, rsp[0].rvalid, k == 1, k == 2);
      end
      tick();
    end
    idle();
    rst_ni = 1'b0;
    tick();
    @(negedge clk_i);
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL unsol_clear got=%b exp=0", err);
    end
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset_inflight();
    do_reset();
    req[0].req = 1'b1; req[0].a.addr = 32'h30;
    mrsp.gnt = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if ({rsp[1].gnt, rsp[0].gnt} !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_if_gnt got=%b%b exp=01", rsp[1].gnt, rsp[0].gnt);
    end
    tick();
    idle();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if ({err, dut.cnt_q, dut.rr_ptr_q} !== '0) begin
      n_fail++;
      $display("FAIL rst_if_state got err=%b cnt=%0d ptr=%0d exp 0/0/0", err, dut.cnt_q, dut.rr_ptr_q);
    end
    tick();
    req[1].req = 1'b1; req[1].a.addr = 32'h14;
    mrsp.gnt = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if ({rsp[1].gnt, rsp[0].gnt, mreq.a.addr} !== {2'b10, 32'h14}) begin
      n_fail++;
      $display("FAIL rst_if_req1 got gnt=%b%b addr=%h exp 10/14", rsp[1].gnt, rsp[0].gnt, mreq.a.addr);
    end
    tick();
    idle();
    mrsp.rvalid = 1'b1; mrsp.r.rdata = 32'hC0;
    @(negedge clk_i);
    n_cmp++;
    if ({rsp[1].rvalid, rsp[0].rvalid, rsp[1].r.rdata} !== {2'b10, 32'hC0}) begin
      n_fail++;
      $display("FAIL rst_if_route got rv=%b%b rdata=%h exp 10/C0", rsp[1].rvalid, rsp[0].rvalid,
               rsp[1].r.rdata);
    end
    tick();
    mrsp.r.rdata = 32'hC1;
    @(negedge clk_i);
    n_cmp++;
    if ({err, rsp[1].rvalid, rsp[0].rvalid} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_if_late got err=%b rv=%b%b exp 0/00", err, rsp[1].rvalid, rsp[0].rvalid);
    end
    tick();
    idle();
    @(negedge clk_i);
    n_cmp++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_if_err got=%b exp=1", err);
    end
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_unsolicited();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cnt_obi_arb.md
CNT_OBI_ARB -- requirements
Module: cnt_obi_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of OBI requesters sharing the counter OBI port (legal 2..4).
REQ-002 SHALL have parameter MAX_OUTST, default 2, depth of the in-flight response-routing FIFO (legal 1..4).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_i  input  sbr_obi_req_t[NUM_REQ]  requester address phases.
REQ-006 SHALL have port rsp_o  output  sbr_obi_rsp_t[NUM_REQ]  per-requester gnt/rvalid/rdata.
REQ-007 SHALL have port mgr_req_o  output  sbr_obi_req_t  arbitrated request to the counter OBI port.
REQ-008 SHALL have port mgr_rsp_i  input  sbr_obi_rsp_t  counter OBI response.
REQ-009 SHALL have port err_o  output  1  sticky protocol-error flag.

Function
REQ-010 Arbitration SHALL be round-robin: winner = first i with req_i[i].req, searching from rr_ptr_q upward modulo NUM_REQ.
REQ-011 On a handshake (mgr_req_o.req & mgr_rsp_i.gnt), rr_ptr_q SHALL become (winner+1) mod NUM_REQ on the next edge.
REQ-012 Lock: if mgr_req_o.req is high and gnt is low, the winner SHALL be registered (lock_q=1, lock_idx_q) and held until its handshake, regardless of other requests.
REQ-013 While locked, mgr_req_o SHALL equal req_i[lock_idx_q] unmodified; lock_q SHALL clear on the handshake edge.
REQ-014 mgr_req_o.req SHALL be 0 when no input requests or when FIFO full (count == MAX_OUTST); mgr_req_o.a SHALL otherwise mirror the winner's address phase.
REQ-015 Full gating SHALL use registered count only; a pop in the same cycle does not unblock a request (no bypass).
REQ-016 rsp_o[i].gnt SHALL equal mgr_rsp_i.gnt only for the current winner and mgr_req_o.req high; 0 for all others.
REQ-017 On every handshake the winner index SHALL be pushed to the routing FIFO.
REQ-018 On mgr_rsp_i.rvalid with FIFO non-empty, head index h SHALL be popped; rsp_o[h].rvalid=1 and rsp_o[h].r = mgr_rsp_i.r in that same cycle (zero added latency).
REQ-019 rsp_o[i].rvalid SHALL be 0 for all i != head, and rsp_o[i].r SHALL be '0 when rsp_o[i].rvalid is 0.
REQ-020 Simultaneous push and pop SHALL keep count unchanged and preserve order.
REQ-021 mgr_rsp_i.rvalid with FIFO empty SHALL set err_o next cycle; response dropped; count stays 0.
REQ-022 err_o SHALL remain 1 until reset.
REQ-023 Back-to-back handshakes SHALL be sustained at one per cycle when the FIFO is not full and the counter responds one cycle after grant.
REQ-024 Requester dropping req before gnt while locked is an OBI violation; behaviour SHALL be to keep the lock and forward req=0 (no spurious grant elsewhere).

Reset
REQ-025 While rst_ni=0 at a clock edge: rr_ptr_q=0, lock_q=0, lock_idx_q=0, FIFO count=0, read/write pointers=0, err_o=0.
REQ-026 Immediately after reset all rsp_o rvalid SHALL be 0; gnt/mgr_req_o follow inputs combinationally per REQ-014/016.
REQ-027 Reset asserted mid-transaction SHALL discard all in-flight routing entries; late rvalid after reset with empty FIFO sets err_o per REQ-021.

Verification
REQ-028 Both requesters hold req=1, counter gnt=1 always, rvalid 1 cycle later: grants alternate 0,1,0,1; each rdata returns to the matching requester.
REQ-029 Req0 issues write wdata=0x0000_0005 with gnt held low 3 cycles while req1 also requests: mgr_req_o stays req0's address/wdata all 3 cycles; req1 granted only after req0 handshake.
REQ-030 MAX_OUTST=2, counter withholds rvalid: after 2 handshakes mgr_req_o.req=0 and rsp gnt=0; one rvalid in cycle k -> new grant no earlier than cycle k+1.
REQ-031 Unsolicited mgr_rsp_i.rvalid=1 with FIFO empty: no rsp_o rvalid, err_o=1 next cycle and stays 1 until rst_ni=0.
REQ-032 Reset pulse with one transaction in flight: after release count=0, rr_ptr_q=0, err_o=0; next request from req1 alone is granted at once.
REQ-033 Bench SHALL check with scoreboard that response order per requester equals grant order and no response is duplicated or lost.
